instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 128, meaning number of words, a power of two and at least 2.
REQ-004 SHALL have parameter DEFAULT_WORD, default 32'h08000000, meaning the word returned on a faulting read (jump to 0).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rd_req, input, 1 bit: fetch request.
REQ-008 SHALL have port rd_addr, input, ADDR_WIDTH bits: fetch byte address.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH bits: fetched word, registered.
REQ-010 SHALL have port rd_valid, output, 1 bit: rd_data/rd_err valid this cycle.
REQ-011 SHALL have port rd_err, output, 1 bit: the fetch was misaligned or out of range.
REQ-012 SHALL have port load_en, input, 1 bit: program-load write strobe.
REQ-013 SHALL have port load_addr, input, ADDR_WIDTH bits: load byte address.
REQ-014 SHALL have port load_data, input, DATA_WIDTH bits: load word.
REQ-015 SHALL have port busy, output, 1 bit: a load is in progress; fetches are refused.

Function
REQ-016 Word index SHALL be rd_addr[log2(DEPTH)+1:2]; the fetch is in range only if rd_addr>>2 < DEPTH.
REQ-017 Fetch latency SHALL be exactly 1: rd_req accepted at edge N gives rd_valid=1 during cycle N+1.
REQ-018 A fetch with rd_addr[1:0]!=0 or out of range SHALL return rd_data=DEFAULT_WORD with rd_err=1 and rd_valid=1.
REQ-019 A good fetch SHALL return the stored word with rd_err=0.
REQ-020 With no accepted fetch, rd_valid SHALL be 0 next cycle, and rd_data/rd_err SHALL hold their last values.
REQ-021 FSM states SHALL be IDLE, LOAD and FLUSH.
- IDLE to LOAD on load_en=1.
- LOAD stays while load_en=1; goes to FLUSH when load_en=0.
- FLUSH goes to IDLE after exactly one cycle.
- FLUSH to LOAD if load_en=1 during FLUSH.
REQ-022 busy SHALL equal 1 in LOAD and FLUSH, and in the cycle load_en first rises (combinational OR with load_en).
REQ-023 rd_req SHALL be accepted only when busy=0; a refused request produces rd_valid=0 next cycle and is not queued.
REQ-024 Each cycle with load_en=1, an aligned, in-range load_addr SHALL write load_data at that edge; misaligned or out-of-range load writes SHALL be dropped silently.
REQ-025 A fetch of address A accepted after FLUSH SHALL return the last word loaded to A (read-after-load coherent).

Reset
REQ-026 On reset=1 at an edge: state=IDLE, rd_valid=0, rd_err=0, rd_data=DEFAULT_WORD.
REQ-027 busy SHALL be 0 after reset unless load_en=1.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Reset during LOAD SHALL abort the load; words already written SHALL be retained.
REQ-030 Reset SHALL have priority over load_en and rd_req in the same cycle; no write or fetch occurs.

Configuration
REQ-031 With macro IMEM_LOAD_EN defined, the load port and the LOAD/FLUSH states SHALL be present as specified.
REQ-032 Without IMEM_LOAD_EN, load_en/load_addr/load_data SHALL be ignored, busy SHALL be constant 0, the FSM stays in IDLE, and the memory is read-only with elaboration-time contents.

Verification
REQ-033 Load 0x20080040 at 0x0, then idle 2 cycles, then rd_req at 0x0 -> next cycle rd_valid=1, rd_data=0x20080040, rd_err=0.
REQ-034 rd_req at 0x2 -> next cycle rd_data=0x08000000, rd_err=1; rd_req at 0x200 (DEPTH=128) -> same.
REQ-035 rd_req during LOAD, and during the FLUSH cycle -> rd_valid=0 the next cycle; busy=1 in both.
REQ-036 Back-to-back rd_req at 0x0, 0x4, 0x8 -> rd_valid=1 for 3 consecutive cycles with matching words in order.
REQ-037 Reset asserted mid-load after 2 of 4 writes -> busy=0 and rd_valid=0 next cycle; words 0 and 1 read back correctly.
REQ-038 Build without IMEM_LOAD_EN; pulse load_en at 0x0 with 0xFFFFFFFF -> busy stays 0 and the word at 0x0 is unchanged.

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory: one-cycle registered fetch with alignment/range fault reporting.
// Define IMEM_LOAD_EN to add the program-load port and its IDLE/LOAD/FLUSH sequencer.
module instr_mem #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    DEPTH        = 128,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(32'h08000000)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  busy
);

   localparam int                    IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_ok;
   logic                  rd_accept;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;

   assign rd_idx    = rd_addr[IDX_W+1:2];
   assign rd_ok     = (rd_addr[1:0] == 2'b00) && ((rd_addr >> 2) < DEPTH_A);
   assign rd_accept = rd_req && !busy;

`ifdef IMEM_LOAD_EN
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      ld_idx;
   logic                  ld_ok;

   assign ld_idx  = load_addr[IDX_W+1:2];
   assign ld_ok   = (load_addr[1:0] == 2'b00) && ((load_addr >> 2) < DEPTH_A);
   assign busy    = load_en || (state_q != S_IDLE);
   assign rd_word = mem[rd_idx];

   // FLUSH keeps fetches off for one cycle after the last load strobe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load_en) state_d = S_LOAD;
         S_LOAD:  if (!load_en) state_d = S_FLUSH;
         S_FLUSH: state_d = load_en ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory has no reset; a reset edge only suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && load_en && ld_ok) begin
         mem[ld_idx] <= load_data;
      end
   end
`else
   logic unused_load;

   // Read-only image: each word holds C0DE0000 ORed with its own byte address.
   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [IDX_W-1:0] idx);
      return DATA_WIDTH'(32'hC0DE0000) | DATA_WIDTH'({idx, 2'b00});
   endfunction

   assign unused_load = ^{load_en, load_addr, load_data};
   assign busy        = 1'b0;
   assign rd_word     = rom_word(rd_idx);
`endif

   always_comb begin
      rd_valid_d = rd_accept;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (rd_accept) begin
         rd_err_d  = !rd_ok;
         rd_data_d = rd_ok ? rd_word : DEFAULT_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= DEFAULT_WORD;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: directed literal checks plus randomized traffic against a reference model.
// Covers both builds; define IMEM_LOAD_EN here as for the design to exercise the load port.
module tb_instr_mem;

   localparam int          DEPTH = 128;
   localparam logic [31:0] DEF   = 32'h08000000;

   logic        clk = 1'b0;
   logic        reset, rd_req, load_en;
   logic [31:0] rd_addr, load_addr, load_data;
   logic [31:0] rd_data;
   logic        rd_valid, rd_err, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [31:0] mm [int unsigned];
   logic [1:0]  hist = 2'b00;
   logic        exp_valid = 1'b0;
   logic [33:0] exp_q[$];
   logic [31:0] last_data = DEF;
   logic        last_err = 1'b0;
   logic        last_known = 1'b1;
   logic        checking = 1'b0;

   instr_mem dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic r, input logic [31:0] a);
      rd_req  = r;
      rd_addr = a;
   endtask

   task automatic set_ld(input logic e, input logic [31:0] a, input logic [31:0] d);
      load_en   = e;
      load_addr = a;
      load_data = d;
   endtask

   function automatic logic model_busy();
`ifdef IMEM_LOAD_EN
      return load_en || (hist != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Expected fetch result: {known, err, word}
   function automatic logic [33:0] fetch_result(input logic [31:0] a);
      logic [31:0] w;
      logic        known;
      if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) return {1'b1, 1'b1, DEF};
`ifdef IMEM_LOAD_EN
      known = mm.exists(a >> 2);
      w     = known ? mm[a >> 2] : 32'h0;
`else
      known = 1'b1;
      w     = 32'hC0DE0000 | a;
`endif
      return {known, 1'b0, w};
   endfunction

   // Reference model: busy is "load_en now or in either of the two previous cycles".
   always @(posedge clk) begin
      logic [33:0] r;
      if (reset) begin
         checking   = 1'b1;
         hist       = 2'b00;
         exp_valid  = 1'b0;
         last_data  = DEF;
         last_err   = 1'b0;
         last_known = 1'b1;
         exp_q.delete();
      end else begin
         exp_valid = rd_req && !model_busy();
         if (exp_valid) begin
            r = fetch_result(rd_addr);
            exp_q.push_back(r);
            last_known = r[33];
            last_err   = r[32];
            last_data  = r[31:0];
         end
`ifdef IMEM_LOAD_EN
         if (load_en && load_addr[1:0] == 2'b00 && (load_addr >> 2) < DEPTH)
            mm[load_addr >> 2] = load_data;
         hist = {hist[0], load_en};
`endif
      end
   end

   always @(negedge clk) begin
      logic [33:0] e;
      if (checking) begin
         chk("busy", busy, model_busy());
         chk("rd_valid", rd_valid, exp_valid);
         if (exp_valid) begin
            if (exp_q.size() == 0) begin
               chk("exp_q_empty", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rd_err", rd_err, e[32]);
               if (e[33]) chk("rd_data", rd_data, e[31:0]);
            end
         end else begin
            chk("rd_err_hold", rd_err, last_err);
            if (last_known) chk("rd_data_hold", rd_data, last_data);
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      int          burst;
      reset = 1'b1;
      set_rd(0, 0);
      set_ld(0, 0, 0);
      tick();
      tick();
      chk("rst_valid", rd_valid, 0);
      chk("rst_err", rd_err, 0);
      chk("rst_data", rd_data, DEF);
      reset = 1'b0;
      chk("rst_busy", busy, 0);

`ifdef IMEM_LOAD_EN
      set_ld(1, 32'h48, 32'h48484848);
      tick();
      set_ld(0, 0, 0);
      tick();
      tick();
      // load then fetch while LOAD and FLUSH are active
      set_ld(1, 32'h0, 32'h20080040);
      chk("busy_rise", busy, 1);
      tick();
      set_ld(0, 0, 0);
      set_rd(1, 32'h0);
      chk("busy_load", busy, 1);
      tick();
      chk("refuse_load", rd_valid, 0);
      chk("busy_flush", busy, 1);
      tick();
      chk("refuse_flush", rd_valid, 0);
      set_rd(0, 0);
      tick();
      tick();
      set_rd(1, 32'h0);
      tick();
      chk("r0_valid", rd_valid, 1);
      chk("r0_data", rd_data, 32'h20080040);
      chk("r0_err", rd_err, 0);
      set_rd(0, 0);
      set_ld(1, 32'h4, 32'h11111111);
      tick();
      set_ld(1, 32'h8, 32'h22222222);
      tick();
      set_ld(1, 32'h2, 32'hDEADBEEF);
      tick();
      set_ld(1, 32'h200, 32'hDEADBEEF);
      tick();
      set_ld(0, 0, 0);
      tick();
      tick();
      tick();
`else
      set_ld(1, 32'h0, 32'hFFFFFFFF);
      chk("rom_busy_rise", busy, 0);
      tick();
      set_ld(0, 0, 0);
      chk("rom_busy_after", busy, 0);
      set_rd(1, 32'h0);
      tick();
      chk("rom_r0_data", rd_data, 32'hC0DE0000);
      set_rd(1, 32'h1FC);
      tick();
      chk("rom_top_data", rd_data, 32'hC0DE01FC);
      chk("rom_top_err", rd_err, 0);
`endif
      // back-to-back fetches
      set_rd(1, 32'h0);
      tick();
      chk("b2b0_valid", rd_valid, 1);
`ifdef IMEM_LOAD_EN
      chk("b2b0_data", rd_data, 32'h20080040);
`else
      chk("b2b0_data", rd_data, 32'hC0DE0000);
`endif
      set_rd(1, 32'h4);
      tick();
      chk("b2b1_valid", rd_valid, 1);
`ifdef IMEM_LOAD_EN
      chk("b2b1_data", rd_data, 32'h11111111);
`else
      chk("b2b1_data", rd_data, 32'hC0DE0004);
`endif
      set_rd(1, 32'h8);
      tick();
      chk("b2b2_valid", rd_valid, 1);
`ifdef IMEM_LOAD_EN
      chk("b2b2_data", rd_data, 32'h22222222);
`else
      chk("b2b2_data", rd_data, 32'hC0DE0008);
`endif
      set_rd(1, 32'h2);
      tick();
      chk("mis_data", rd_data, DEF);
      chk("mis_err", rd_err, 1);
      set_rd(1, 32'h200);
      tick();
      chk("oor_data", rd_data, DEF);
      chk("oor_err", rd_err, 1);
      chk("oor_valid", rd_valid, 1);
      set_rd(0, 0);
      tick();
      chk("idle_valid", rd_valid, 0);
      chk("idle_err_hold", rd_err, 1);

`ifdef IMEM_LOAD_EN
      // reset aborts a 4-word load after two writes
      set_ld(1, 32'h40, 32'hA0A0A0A0);
      tick();
      set_ld(1, 32'h44, 32'hA1A1A1A1);
      tick();
      reset = 1'b1;
      set_rd(1, 32'h0);
      set_ld(1, 32'h48, 32'hA2A2A2A2);
      tick();
      reset = 1'b0;
      set_rd(0, 0);
      set_ld(0, 0, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", rd_valid, 0);
      set_rd(1, 32'h40);
      tick();
      chk("abort_w0", rd_data, 32'hA0A0A0A0);
      set_rd(1, 32'h44);
      tick();
      chk("abort_w1", rd_data, 32'hA1A1A1A1);
      set_rd(1, 32'h48);
      tick();
      chk("abort_w2_kept", rd_data, 32'h48484848);
      set_rd(0, 0);
`else
      reset = 1'b1;
      set_rd(1, 32'h4);
      tick();
      reset = 1'b0;
      set_rd(0, 0);
      chk("rom_rst_valid", rd_valid, 0);
      chk("rom_rst_data", rd_data, DEF);
`endif

      // randomized traffic
      burst = 0;
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         case ($urandom_range(0, 9))
            0:       a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
            1:       a = (DEPTH * 4) + ($urandom_range(0, 255) << 2);
            default: a = $urandom_range(0, 15) << 2;
         endcase
         set_rd($urandom_range(0, 2) != 0, a);
         if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 4);
         d = $urandom;
         if (burst > 0) begin
            case ($urandom_range(0, 7))
               0:       a = 32'h1 | ($urandom_range(0, 15) << 2);
               1:       a = 32'h400;
               default: a = $urandom_range(0, 15) << 2;
            endcase
            set_ld(1, a, d);
            burst--;
         end else begin
            set_ld(0, 32'h0, d);
         end
         tick();
      end
      reset = 1'b0;
      set_rd(0, 0);
      set_ld(0, 0, 0);
      repeat (4) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
